blit_bus_decode: RTL and testbench

BLIT_BUS_DECODE -- requirements
Module: blit_bus_decode

---
 rtl/blit_bus_decode_if.sv | 52 +++++
 rtl/blit_bus_decode.sv | 163 ++++++++++++++++
 tb/tb_blit_bus_decode.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/blit_bus_decode_if.sv
// blit_bus_decode_if -- bundled CPU-side and slave-side bus signals for the
// blitter address decoder.
//
//   cpu_req/cpu_we/cpu_addr/cpu_wdata/cpu_wstrb : CPU request, held until ack
//   cpu_ack/cpu_err/cpu_rdata                   : completion pulse, error, data
//   slv_req/slv_addr/slv_wdata/slv_wstrb/slv_we : one-hot request + shared bus
//   slv_ack/slv_rdata                           : per-slave ack and read lanes
//   bootup                                      : boot overlay enable
//   err_addr/err_cause                          : sticky last-error record
//
// modport master : the environment (CPU plus slave array) around the decoder
// modport slave  : the decoder itself
interface blit_bus_decode_if #(
  parameter int unsigned NSLAVE = 3,
  parameter int unsigned AW     = 24,
  parameter int unsigned DW     = 16
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [AW-1:0]        cpu_addr;
  logic [DW-1:0]        cpu_wdata;
  logic [DW/8-1:0]      cpu_wstrb;
  logic                 cpu_ack;
  logic                 cpu_err;
  logic [DW-1:0]        cpu_rdata;
  logic [NSLAVE-1:0]    slv_req;
  logic [AW-1:0]        slv_addr;
  logic [DW-1:0]        slv_wdata;
  logic [DW/8-1:0]      slv_wstrb;
  logic                 slv_we;
  logic [NSLAVE-1:0]    slv_ack;
  logic [NSLAVE*DW-1:0] slv_rdata;
  logic                 bootup;
  logic [AW-1:0]        err_addr;
  logic [1:0]           err_cause;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output slv_ack, slv_rdata, bootup,
    input  cpu_ack, cpu_err, cpu_rdata,
    input  slv_req, slv_addr, slv_wdata, slv_wstrb, slv_we,
    input  err_addr, err_cause
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  slv_ack, slv_rdata, bootup,
    output cpu_ack, cpu_err, cpu_rdata,
    output slv_req, slv_addr, slv_wdata, slv_wstrb, slv_we,
    output err_addr, err_cause
  );
endinterface

// File: rtl/blit_bus_decode.sv
// blit_bus_decode -- CPU address decoder for the blitter bus.
//
// Decodes one CPU access at a time onto NSLAVE mask/base windows (lowest
// index wins), with a boot overlay below BOOT_LIMIT served by BOOT_SLAVE
// while bootup is high. Selected slaves get a 1-cycle one-hot slv_req, and
// the first slv_ack from that slave completes the access one cycle later.
// Unmapped accesses, overlay violations and wait timeouts complete with an
// error pulse and are recorded in err_addr/err_cause (1 unmapped, 2 timeout,
// 3 overlay violation). A one-cycle DONE state after every completion stops
// a held cpu_req from retriggering.
//
// Ports: clk, rst_n (async, active-low), bus (blit_bus_decode_if.slave).
module blit_bus_decode #(
  parameter int unsigned           NSLAVE       = 3,
  parameter int unsigned           AW           = 24,
  parameter int unsigned           DW           = 16,
  parameter logic [NSLAVE*AW-1:0]  SLV_BASE     = {24'h060000, 24'h040000, 24'h000000},
  parameter logic [NSLAVE*AW-1:0]  SLV_MASK     = {24'hFFFF00, 24'hFF0000, 24'hFC0000},
  parameter int unsigned           BOOT_LIMIT   = 8,
  parameter int unsigned           BOOT_SLAVE   = 1,
  parameter int unsigned           TIMEOUT      = 255,
  parameter bit                    UNMAPPED_ERR = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  blit_bus_decode_if.slave bus
);

  localparam int unsigned SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NSLAVE-1:0] slv_req_q, slv_req_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [AW-1:0]     eaddr_q, eaddr_d;
  logic [1:0]        ecause_q, ecause_d;

  logic              dec_hit;
  logic [SW-1:0]     dec_sel;
  logic              in_boot;
  logic              ack_sel;

  // Window match with lowest-index priority.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < NSLAVE; i++) begin
      if (!dec_hit &&
          ((bus.cpu_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(i);
      end
    end
  end

  assign in_boot = (bus.cpu_addr < AW'(BOOT_LIMIT));
  // Only the selected slave's ack bit is looked at.
  assign ack_sel = |(bus.slv_ack & (NSLAVE'(1) << sel_q));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    slv_req_d = '0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    eaddr_d   = eaddr_q;
    ecause_d  = ecause_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (in_boot && !bus.bootup) begin
            ack_d    = 1'b1;
            err_d    = 1'b1;
            ecause_d = 2'd3;
            eaddr_d  = bus.cpu_addr;
            state_d  = DONE;
          end else if (in_boot || dec_hit) begin
            sel_d     = in_boot ? SW'(BOOT_SLAVE) : dec_sel;
            slv_req_d = NSLAVE'(1) << sel_d;
            cnt_d     = '0;
            state_d   = WAIT;
          end else begin
            ack_d    = 1'b1;
            err_d    = UNMAPPED_ERR;
            ecause_d = 2'd1;
            eaddr_d  = bus.cpu_addr;
            state_d  = DONE;
          end
        end
      end
      WAIT: begin
        // Ack is tested first so an ack on the timeout cycle completes cleanly.
        if (ack_sel) begin
          rdata_d = bus.slv_rdata[sel_q*DW +: DW];
          ack_d   = 1'b1;
          state_d = DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
          ack_d    = 1'b1;
          err_d    = 1'b1;
          ecause_d = 2'd2;
          eaddr_d  = bus.cpu_addr;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      slv_req_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      eaddr_q   <= '0;
      ecause_q  <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      slv_req_q <= slv_req_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      eaddr_q   <= eaddr_d;
      ecause_q  <= ecause_d;
    end
  end

  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.slv_req   = slv_req_q;
  assign bus.err_addr  = eaddr_q;
  assign bus.err_cause = ecause_q;
  assign bus.slv_addr  = bus.cpu_addr;
  assign bus.slv_wdata = bus.cpu_wdata;
  assign bus.slv_wstrb = bus.cpu_wstrb;
  assign bus.slv_we    = bus.cpu_we;

endmodule

// File: tb/tb_blit_bus_decode.sv
// Self-checking bench for blit_bus_decode: table of directed vectors,
// randomized accesses against a behavioural decode/latency model, and
// hand-written sequences for timeout, held request and reset in WAIT.
module tb_blit_bus_decode;
  localparam int unsigned NS = 3;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int          TO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  blit_bus_decode_if #(.NSLAVE(NS), .AW(AW), .DW(DW)) bus ();
  blit_bus_decode_if #(.NSLAVE(NS), .AW(AW), .DW(DW)) bus1 ();

  // Second DUT sees the same stimulus but reports unmapped accesses without error.
  assign bus1.cpu_req   = bus.cpu_req;
  assign bus1.cpu_we    = bus.cpu_we;
  assign bus1.cpu_addr  = bus.cpu_addr;
  assign bus1.cpu_wdata = bus.cpu_wdata;
  assign bus1.cpu_wstrb = bus.cpu_wstrb;
  assign bus1.slv_ack   = bus.slv_ack;
  assign bus1.slv_rdata = bus.slv_rdata;
  assign bus1.bootup    = bus.bootup;

  blit_bus_decode #(.NSLAVE(NS), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  blit_bus_decode #(.NSLAVE(NS), .AW(AW), .DW(DW), .TIMEOUT(TO), .UNMAPPED_ERR(1'b0)) dut_noerr (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic        boot;
    int          dly;        // slave ack this many cycles after slv_req; -1 never
    logic [15:0] data;
    logic [2:0]  exp_req;
    int          exp_lat;    // cycle (1 = first edge after req) of cpu_ack
    logic        exp_err;
    logic        exp_err1;   // cpu_err of the UNMAPPED_ERR=0 instance
    logic [1:0]  exp_cause;  // 0: error record must stay unchanged
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [15:0] m_rdata = '0;
  logic [23:0] m_eaddr = '0;
  logic [1:0]  m_cause = '0;

  logic [23:0] win_base [3] = '{24'h000000, 24'h040000, 24'h060000};
  logic [23:0] win_mask [3] = '{24'hFC0000, 24'hFF0000, 24'hFFFF00};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 64'(bus.cpu_ack), 0);
    chk({tag, "_err"}, 64'(bus.cpu_err), 0);
    chk({tag, "_rdata"}, 64'(bus.cpu_rdata), 0);
    chk({tag, "_slv_req"}, 64'(bus.slv_req), 0);
    chk({tag, "_err_addr"}, 64'(bus.err_addr), 0);
    chk({tag, "_err_cause"}, 64'(bus.err_cause), 0);
  endtask

  function automatic vec_t mk(logic [23:0] a, logic we, logic boot, int dly, logic [15:0] d,
                              logic [2:0] rq, int lat, logic e, logic e1, logic [1:0] cz);
    vec_t v;
    v.addr = a; v.we = we; v.boot = boot; v.dly = dly; v.data = d;
    v.exp_req = rq; v.exp_lat = lat; v.exp_err = e; v.exp_err1 = e1; v.exp_cause = cz;
    return v;
  endfunction

  // Reference: decode rules and latency arithmetic straight from the rules.
  function automatic vec_t model(logic [23:0] a, logic we, logic boot, int dly, logic [15:0] d);
    int sel;
    sel = -1;
    if (a < 24'd8) sel = boot ? 1 : -2;
    else
      for (int i = 0; i < 3; i++)
        if (sel == -1 && (a & win_mask[i]) == win_base[i]) sel = i;
    if (sel == -2)      return mk(a, we, boot, dly, d, 3'b000, 1, 1'b1, 1'b1, 2'd3);
    else if (sel == -1) return mk(a, we, boot, dly, d, 3'b000, 1, 1'b1, 1'b0, 2'd1);
    else if (dly >= 0 && dly <= TO - 1)
      return mk(a, we, boot, dly, d, 3'(1 << sel), 2 + dly, 1'b0, 1'b0, 2'd0);
    else
      return mk(a, we, boot, dly, d, 3'(1 << sel), TO + 1, 1'b1, 1'b1, 2'd2);
  endfunction

  task automatic run_vec(input vec_t v, input bit noisy);
    logic [NS-1:0]    ack_vec;
    logic [NS*DW-1:0] rd;
    logic [2:0]       first_req;
    logic [15:0]      wd;
    logic [1:0]       ws;
    logic             err0, err1_v, ack1;
    int               sel, ack_at, nreq, bound;
    sel = -1;
    for (int i = 0; i < NS; i++) if (v.exp_req[i]) sel = i;
    wd = 16'($urandom);
    ws = 2'($urandom);
    bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr;
    bus.cpu_wdata = wd; bus.cpu_wstrb = ws; bus.bootup = v.boot;
    bus.slv_ack = noisy ? NS'($urandom) : '0;
    bus.slv_rdata = {$urandom, $urandom};
    ack_at = -1; nreq = 0; first_req = '0; bound = v.exp_lat + 4;
    err0 = 1'bx; err1_v = 1'bx; ack1 = 1'bx;
    for (int c = 1; c <= bound && ack_at < 0; c++) begin
      @(posedge clk); #1;
      if (bus.slv_req != '0) nreq++;
      if (c == 1) begin
        first_req = bus.slv_req;
        chk("slv_addr", 64'(bus.slv_addr), 64'(v.addr));
        chk("slv_we", 64'(bus.slv_we), 64'(v.we));
        chk("slv_wdata", 64'(bus.slv_wdata), 64'(wd));
        chk("slv_wstrb", 64'(bus.slv_wstrb), 64'(ws));
        bus.cpu_req = 1'b0;
      end
      if (bus.cpu_ack) begin
        ack_at = c; err0 = bus.cpu_err; err1_v = bus1.cpu_err; ack1 = bus1.cpu_ack;
      end
      ack_vec = noisy ? (NS'($urandom) & ~v.exp_req) : '0;
      rd = {$urandom, $urandom};
      if (sel >= 0 && v.dly >= 0 && c == 1 + v.dly) begin
        ack_vec = ack_vec | v.exp_req;
        rd[sel*DW +: DW] = v.data;
      end
      bus.slv_ack = ack_vec;
      bus.slv_rdata = rd;
    end
    if (v.exp_cause != 2'd0) begin
      m_eaddr = v.addr; m_cause = v.exp_cause;
    end else begin
      m_rdata = v.data;
    end
    chk("ack_latency", 64'(ack_at), 64'(v.exp_lat));
    chk("slv_req_onehot", 64'(first_req), 64'(v.exp_req));
    chk("slv_req_count", 64'(nreq), (v.exp_req != 0) ? 1 : 0);
    chk("cpu_err", 64'(err0), 64'(v.exp_err));
    chk("noerr_ack", 64'(ack1), 1);
    chk("noerr_cpu_err", 64'(err1_v), 64'(v.exp_err1));
    chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(m_rdata));
    chk("err_cause", 64'(bus.err_cause), 64'(m_cause));
    chk("err_addr", 64'(bus.err_addr), 64'(m_eaddr));
    // DONE cycle: any ack noise here must not matter.
    bus.slv_ack = noisy ? NS'($urandom) : '0;
    @(posedge clk); #1;
    chk("ack_pulse", 64'(bus.cpu_ack), 0);
    bus.slv_ack = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [23:0] a;
    logic [12:0] reqmask, ackmask;
    int dly, nack, nreq;
    bit pend;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_wstrb = '0; bus.slv_ack = '0; bus.slv_rdata = '0; bus.bootup = 1'b0;

    tbl.push_back(mk(24'h040010, 0, 0, 3,   16'hBEEF, 3'b010, 5,   0, 0, 0));
    tbl.push_back(mk(24'h000004, 0, 1, 0,   16'h1234, 3'b010, 2,   0, 0, 0));
    tbl.push_back(mk(24'h000004, 1, 0, 0,   16'h0000, 3'b000, 1,   1, 1, 3));
    tbl.push_back(mk(24'h800000, 0, 0, 0,   16'h0000, 3'b000, 1,   1, 0, 1));
    tbl.push_back(mk(24'h000010, 1, 0, 0,   16'hA5A5, 3'b001, 2,   0, 0, 0));
    tbl.push_back(mk(24'h060020, 0, 0, 254, 16'h7E57, 3'b100, 256, 0, 0, 0));
    tbl.push_back(mk(24'h03FFFF, 0, 0, 1,   16'h0F0F, 3'b001, 3,   0, 0, 0));
    tbl.push_back(mk(24'h0600FF, 0, 1, 2,   16'hC0DE, 3'b100, 4,   0, 0, 0));
    tbl.push_back(mk(24'h060100, 0, 0, 0,   16'h0000, 3'b000, 1,   1, 0, 1));
    tbl.push_back(mk(24'h000008, 0, 0, 0,   16'h1111, 3'b001, 2,   0, 0, 0));
    tbl.push_back(mk(24'h000007, 0, 1, 5,   16'h2222, 3'b010, 7,   0, 0, 0));
    tbl.push_back(mk(24'h050000, 1, 1, 0,   16'h0000, 3'b000, 1,   1, 0, 1));
    tbl.push_back(mk(24'h04FFFF, 0, 0, 0,   16'h3333, 3'b010, 2,   0, 0, 0));

    #2 rst_n = 1'b0;
    #1 chk_zero("reset_async");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    chk_zero("reset_release");

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: a = 24'($urandom_range(0, 15));
        1: a = 24'($urandom_range(0, 24'h03FFFF));
        2: a = {8'h04, 16'($urandom)};
        3: a = 24'h060000 | 24'($urandom_range(0, 511));
        4: a = 24'($urandom);
        default: a = {8'h05, 16'($urandom)};
      endcase
      if ($urandom_range(0, 19) == 0) dly = -1;
      else if ($urandom_range(0, 13) == 0) dly = int'($urandom_range(250, 258));
      else dly = int'($urandom_range(0, 6));
      v = model(a, 1'($urandom), 1'($urandom), dly, 16'($urandom));
      run_vec(v, 1'b1);
    end

    // Timeout, then a stale ack from the timed-out slave ten cycles later.
    run_vec(mk(24'h060020, 0, 0, -1, 16'h0000, 3'b100, 256, 1, 1, 2), 1'b0);
    nack = 0; nreq = 0;
    for (int c = 1; c <= 14; c++) begin
      bus.slv_ack = (c == 9) ? 3'b100 : 3'b000;
      @(posedge clk); #1;
      if (bus.cpu_ack) nack++;
      if (bus.slv_req != '0) nreq++;
    end
    bus.slv_ack = '0;
    chk("late_ack_ignored", 64'(nack), 0);
    chk("late_ack_no_req", 64'(nreq), 0);
    chk("late_ack_rdata", 64'(bus.cpu_rdata), 64'(m_rdata));

    // Held request, slave acks one cycle after each slv_req: req, wait, ack,
    // DONE gap, then the next decode -> slv_req every 4 cycles.
    bus.cpu_req = 1'b1; bus.cpu_addr = 24'h040010; bus.bootup = 1'b0; bus.cpu_we = 1'b0;
    reqmask = '0; ackmask = '0; pend = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.slv_req != '0) reqmask[c] = 1'b1;
      if (bus.cpu_ack) ackmask[c] = 1'b1;
      bus.slv_ack = pend ? 3'b010 : 3'b000;
      bus.slv_rdata = {16'h0, 16'h4B1D, 16'h0};
      pend = (bus.slv_req == 3'b010);
    end
    bus.cpu_req = 1'b0; bus.slv_ack = '0;
    m_rdata = 16'h4B1D;
    chk("hold_req_pattern", 64'(reqmask), 64'(13'h0222));
    chk("hold_ack_pattern", 64'(ackmask), 64'(13'h0888));
    chk("hold_rdata", 64'(bus.cpu_rdata), 64'(m_rdata));
    @(posedge clk); #1;

    // Reset while waiting on slave 2; the late ack must not complete anything.
    bus.cpu_req = 1'b1; bus.cpu_addr = 24'h060020; bus.slv_ack = '0;
    @(posedge clk); #1;
    chk("wait_rst_req", 64'(bus.slv_req), 64'(3'b100));
    bus.cpu_req = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("wait_rst");
    @(posedge clk); #3 rst_n = 1'b1;
    m_rdata = '0; m_eaddr = '0; m_cause = '0;
    nack = 0;
    bus.slv_ack = 3'b100;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.cpu_ack) nack++;
    end
    bus.slv_ack = '0;
    chk("wait_rst_no_ack", 64'(nack), 0);
    run_vec(tbl[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
